serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder sequencer built around the team's two-input half-adder cell. It captures two W-bit operands on a start request and pushes them LSB-first through one shared bit-slice, one bit per clock. The bit-slice is two half-adder stages plus an OR for carry-out, so only one bit of add logic is needed. The full W+1-bit sum is registered on a one-cycle done pulse. The block sits between a requester issuing add commands and the shared half-adder datapath, and owns all sequencing, operand shifting and carry state.

## Interface
Parameters:
- W, 8, operand width in bits; legal range 1..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  add request; sampled only in IDLE or DONE.
- a  input  W  operand A; captured on an accepted start.
- b  input  W  operand B; captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  high for exactly one cycle, while in DONE.
- sum  output  W+1  registered result {carry_out, sum bits}; holds its value until the next completion.

## Operation
- The FSM has three states: IDLE, RUN and DONE. There are no unused encodings; any illegal state returns to IDLE.
- Internal state:
  - sa, sb: W-bit operand shift registers.
  - cy: 1-bit carry register.
  - acc: W-bit result shift register.
  - cnt: bit counter, width clog2(W) with a minimum of 1.
- IDLE:
  - If start=1, load sa<=a, sb<=b, cy<=0, cnt<=0, and go to RUN.
  - Otherwise, stay in IDLE.
- RUN computes one bit per cycle:
  - Stage 1 half adder: p = sa[0]^sb[0], g1 = sa[0]&sb[0].
  - Stage 2 half adder: s = p^cy, g2 = p&cy.
  - Carry-out: co = g1|g2.
  - Register updates: acc <= {s, acc[W-1:1]}; sa, sb shift right by 1 with 0 fill; cy <= co; cnt <= cnt+1.
  - When cnt==W-1, the slice step still executes, then sum <= {co, s, acc[W-1:1]} and the FSM goes to DONE.
- DONE:
  - done=1 for this cycle.
  - If start=1, accept exactly as in IDLE and go to RUN. This allows back-to-back operations.
  - Otherwise, go to IDLE.
- A start in RUN is ignored. It is not queued, and the operands are not resampled.
- Arithmetic is unsigned: sum = a + b, width W+1, and no overflow is possible. The MSB of sum is the final carry.
- sum is written only on the RUN→DONE transition. It is never cleared except by reset.

## Timing
- Reset values:
  - state=IDLE; busy=0; done=0; sum=0.
  - sa, sb, acc, cy and cnt are all 0.
  - Reset takes effect immediately, asynchronously to clk.
- Reset during RUN or DONE aborts the operation. No done pulse occurs, and sum returns to 0.
- busy and done are decoded from registered state, so they are glitch-free and change one cycle after the causing edge.
- Sequence, with start accepted at edge k:
  - After edge k, busy=1.
  - Edges k+1 .. k+W process bits 0 .. W-1.
  - After edge k+W, busy=0, done=1 and sum is valid.
  - After edge k+W+1, done=0, unless start was also sampled at edge k+W+1, in which case busy=1.
- Latency from the accepting edge to the done cycle is W clocks.
- Maximum throughput is one result per W+1 clocks.
- W=1: exactly one RUN cycle; the cnt==W-1 condition holds immediately.
- The a and b inputs need to be stable only at the accepting edge.

## Test plan
- **Reset, then single add.** W=8, a=8'hA5, b=8'h5A, start pulsed for 1 cycle.
  - busy high for exactly 8 cycles, then done high for 1 cycle.
  - sum=9'h0FF.
  - sum holds 9'h0FF for 20 idle cycles afterward.
- **Full carry ripple.** a=8'hFF, b=8'h01 → sum=9'h100. Then a=8'hFF, b=8'hFF → sum=9'h1FE.
- **Back-to-back.** Hold start=1 continuously with a=8'h01, b=8'h02, then a=8'h80, b=8'h80 on the next acceptance.
  - done pulses are exactly 9 cycles apart.
  - Sums are 9'h003, then 9'h100.
  - busy is low only during the done cycles.
- **Start while busy.** Start with a=8'h10, b=8'h20; pulse start again with a=8'hFF, b=8'hFF at cycle 3 of RUN.
  - Result is sum=9'h030.
  - Only one done pulse occurs.
  - FSM returns to IDLE.
- **Reset mid-operation.** Assert rst for 1 cycle at RUN cycle 4.
  - busy, done and sum go to 0 immediately, with no done pulse.
  - A subsequent start with a=8'h03, b=8'h04 gives sum=9'h007.
- **Parameter sweep.** W=1: 1+1 → sum=2'b10, with done 1 cycle after acceptance. W=32: random pairs compared against a behavioural a+b, 1000 iterations.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial unsigned adder sequencer: adds two W-bit operands LSB-first through one
// half-adder/half-adder/OR bit-slice, one bit per clock, and registers the W+1-bit sum.
module serial_add_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W:0]   sum
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   sa, sb, acc, acc_nxt;
  logic           cy;
  logic [CW-1:0]  cnt;
  logic           p, g1, s, g2, co;
  logic           last, accept;

  // Shared bit-slice: two half adders plus an OR for carry-out.
  always_comb begin
    p  = sa[0] ^ sb[0];
    g1 = sa[0] & sb[0];
    s  = p ^ cy;
    g2 = p & cy;
    co = g1 | g2;
  end

  assign last = (cnt == CW'(W - 1));

  if (W == 1) begin : g_acc_w1
    assign acc_nxt = s;
  end else begin : g_acc_wn
    assign acc_nxt = {s, acc[W-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every datapath register is reset, so an abort leaves no stale sum or carry behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa  <= '0;
      sb  <= '0;
      acc <= '0;
      cy  <= 1'b0;
      cnt <= '0;
      sum <= '0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      cy  <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      acc <= acc_nxt;
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      cy  <= co;
      cnt <= cnt + CW'(1);
      // The final step's carry and sum bit go straight into the result.
      if (last) sum <= {co, acc_nxt};
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at W=8, W=1 and W=32; expected sums come
// from plain a+b and are popped by per-instance monitors on each done pulse.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, busy8, done8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [8:0]  sum8;
  logic        start1 = 1'b0, busy1, done1;
  logic [0:0]  a1 = '0, b1 = '0;
  logic [1:0]  sum1;
  logic        start32 = 1'b0, busy32, done32;
  logic [31:0] a32 = '0, b32 = '0;
  logic [32:0] sum32;

  serial_add_ctrl #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8));
  serial_add_ctrl #(.W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1));
  serial_add_ctrl #(.W(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .sum(sum32));

  int errors = 0;
  int checks = 0;
  logic [8:0]  q8[$];
  logic [1:0]  q1[$];
  logic [32:0] q32[$];

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop the expected sum on every done pulse.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) check("unexpected_done8", 33'(sum8), 33'h1_FFFF_FFFF);
      else check("sum8", 33'(sum8), 33'(q8.pop_front()));
    end
    if (done1) begin
      if (q1.size() == 0) check("unexpected_done1", 33'(sum1), 33'h1_FFFF_FFFF);
      else check("sum1", 33'(sum1), 33'(q1.pop_front()));
    end
    if (done32) begin
      if (q32.size() == 0) check("unexpected_done32", sum32, 33'h1_FFFF_FFFF);
      else check("sum32", sum32, q32.pop_front());
    end
  end

  // Returns 1ns after the accepting edge with start deasserted.
  task automatic issue8(input logic [7:0] x, input logic [7:0] y, input bit expect_done);
    @(posedge clk); #1;
    start8 = 1'b1; a8 = x; b8 = y;
    if (expect_done) q8.push_back({1'b0, x} + {1'b0, y});
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic wait_done8(input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done8) break;
    end
    check("done8_within_budget", 33'(n < budget), 33'd1);
  endtask

  task automatic wait_done32(input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done32) break;
    end
    check("done32_within_budget", 33'(n < budget), 33'd1);
  endtask

  initial begin
    int bad, ndone, d0, d1;
    logic [31:0] x, y;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy8", 33'(busy8), 33'd0);
    check("rst_done8", 33'(done8), 33'd0);
    check("rst_sum8", 33'(sum8), 33'd0);
    check("rst_sum32", sum32, 33'd0);
    rst = 1'b0;

    // Single add with cycle-exact busy/done timing
    issue8(8'hA5, 8'h5A, 1'b1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!(busy8 && !done8)) bad++;
    end
    check("busy8_eight_cycles", 33'(bad), 33'd0);
    @(negedge clk);
    check("done8_after_w", 33'({busy8, done8}), 33'b01);
    check("sum8_a5_5a", 33'(sum8), 33'h0FF);
    @(negedge clk);
    check("done8_one_cycle", 33'(done8), 33'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sum8 !== 9'h0FF || busy8 || done8) bad++;
    end
    check("sum8_holds_idle", 33'(bad), 33'd0);

    // Full carry ripple
    issue8(8'hFF, 8'h01, 1'b1);
    wait_done8(20);
    issue8(8'hFF, 8'hFF, 1'b1);
    wait_done8(20);

    // Back-to-back with start held high
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
    q8.push_back(9'h003);
    @(posedge clk); #1;
    a8 = 8'h80; b8 = 8'h80;
    q8.push_back(9'h100);
    bad = 0; ndone = 0; d0 = -1; d1 = -1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (!(busy8 ^ done8)) bad++;
      if (done8) begin
        if (ndone == 0) d0 = i; else d1 = i;
        ndone++;
      end
      if (i == 9) start8 = 1'b0;
    end
    check("b2b_busy_low_only_in_done", 33'(bad), 33'd0);
    check("b2b_done_count", 33'(ndone), 33'd2);
    check("b2b_done_spacing", 33'(d1 - d0), 33'd9);
    @(negedge clk);
    check("b2b_back_to_idle", 33'({busy8, done8}), 33'b00);

    // Start while busy is ignored
    issue8(8'h10, 8'h20, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("busy_start_one_done", 33'(ndone), 33'd1);
    check("busy_start_idle", 33'({busy8, done8}), 33'b00);

    // Reset mid-operation
    issue8(8'h55, 8'h66, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy8", 33'(busy8), 33'd0);
    check("midrst_done8", 33'(done8), 33'd0);
    check("midrst_sum8", 33'(sum8), 33'd0);
    @(posedge clk); #1 rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("midrst_no_done", 33'(ndone), 33'd0);
    issue8(8'h03, 8'h04, 1'b1);
    wait_done8(20);

    // W=1: one RUN cycle, done one cycle after acceptance
    @(posedge clk); #1;
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    q1.push_back({1'b0, a1} + {1'b0, b1});
    @(posedge clk); #1;
    start1 = 1'b0;
    @(negedge clk);
    check("w1_busy", 33'({busy1, done1}), 33'b10);
    @(negedge clk);
    check("w1_done", 33'({busy1, done1}), 33'b01);
    check("w1_sum", 33'(sum1), 33'b10);

    // W=32 random sweep, boundaries first
    for (int i = 0; i < 1000; i++) begin
      case (i)
        0: begin x = 32'hFFFF_FFFF; y = 32'hFFFF_FFFF; end
        1: begin x = 32'hFFFF_FFFF; y = 32'h0000_0001; end
        2: begin x = 32'h0;         y = 32'h0;         end
        default: begin x = $urandom; y = $urandom; end
      endcase
      @(posedge clk); #1;
      start32 = 1'b1; a32 = x; b32 = y;
      q32.push_back({1'b0, x} + {1'b0, y});
      @(posedge clk); #1;
      start32 = 1'b0;
      wait_done32(40);
    end

    @(negedge clk);
    check("q8_drained", 33'(q8.size()), 33'd0);
    check("q1_drained", 33'(q1.size()), 33'd0);
    check("q32_drained", 33'(q32.size()), 33'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
